data_ram_ws: RTL and testbench
==============================

DATA_RAM_WS -- requirements
Module: data_ram_ws

Interface
- REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8; NB = DATA_W/8 byte lanes.
- REQ-002 Parameter DEPTH_LOG2, default 10, log2 of the number of words stored.
- REQ-003 Parameter WAIT_CYCLES, default 2, extra wait states per access; the legal range SHALL be 0..15.
- REQ-004 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; SHALL be aligned to NB*2^DEPTH_LOG2.
- REQ-005 Interface: one clock, clk; reset rst is asynchronous and active-high.
- REQ-006 clk  input  1  single clock, rising edge active.
- REQ-007 rst  input  1  asynchronous active-high reset.
- REQ-008 ce  input  1  access request.
- REQ-009 we  input  1  1 = write, 0 = read.
- REQ-010 addr  input  32  byte address.
- REQ-011 sel  input  NB  byte-lane enables; bit i selects data bits [8i+7:8i].
- REQ-012 data_i  input  DATA_W  write data.
- REQ-013 data_o  output  DATA_W  read data, registered.
- REQ-014 ack_o  output  1  one-cycle completion pulse.
- REQ-015 busy_o  output  1  access outstanding, not yet acknowledged.
- REQ-016 err_o  output  1  out-of-range access; valid with ack_o.

Function
- REQ-017 The FSM SHALL have three states: IDLE, WAIT and ACK.
- REQ-018 A request SHALL be accepted on a rising edge when ce=1 and the state is IDLE or ACK.
- REQ-019 On acceptance, the block SHALL latch we, addr, sel and data_i; after acceptance, the inputs are don't-care until ack_o.
- REQ-020 On acceptance with WAIT_CYCLES=0, the next state SHALL be ACK.
- REQ-021 On acceptance with WAIT_CYCLES>0, the next state SHALL be WAIT and the wait counter SHALL load WAIT_CYCLES-1.
- REQ-022 In WAIT, the counter SHALL decrement each cycle; when the counter is 0, the next state SHALL be ACK.
- REQ-023 ACK SHALL last exactly one cycle; the next state SHALL be IDLE if ce=0, or the accepted-request path of REQ-020/REQ-021 if ce=1.
- REQ-024 Latency: ack_o SHALL be high in the cycle that begins WAIT_CYCLES+1 rising edges after the acceptance edge.
- REQ-025 Throughput SHALL be one access per WAIT_CYCLES+1 cycles; with WAIT_CYCLES=0, ack_o SHALL be high on consecutive cycles.
- REQ-026 ack_o SHALL equal (state==ACK).
- REQ-027 busy_o SHALL equal (state==WAIT).
- REQ-028 Dropping ce during WAIT SHALL NOT cancel the latched request.
- REQ-029 Word index SHALL be (addr - BASE_ADDR) >> log2(NB), truncated to DEPTH_LOG2 bits; addr low bits SHALL be ignored.
- REQ-030 A latched address is in range iff BASE_ADDR <= addr <= BASE_ADDR + NB*2^DEPTH_LOG2 - 1.
- REQ-031 In-range write: the array SHALL be updated on the edge entering ACK, only in lanes whose sel bit = 1; other lanes SHALL keep their contents.
- REQ-032 A write with sel = 0 SHALL be acknowledged with no array change.
- REQ-033 In-range read: data_o SHALL load the full word on the edge entering ACK; sel SHALL be ignored.
- REQ-034 After a write, data_o SHALL hold its previous value.
- REQ-035 data_o SHALL hold its value until the next read completes.
- REQ-036 Out-of-range access: there SHALL be no array write; data_o SHALL load 0; err_o SHALL be 1 while ack_o=1.
- REQ-037 err_o SHALL be 0 whenever ack_o=0.
- REQ-038 A read completing in the ACK cycle immediately after a write to the same word SHALL return the newly written data.

Reset
- REQ-039 While rst=1, the state SHALL be IDLE and the wait counter SHALL be 0.
- REQ-040 While rst=1, data_o, ack_o, busy_o and err_o SHALL be 0.
- REQ-041 Reset asserted mid-access SHALL abort the access; no ack_o SHALL follow.
- REQ-042 An aborted write SHALL NOT modify the array if reset asserts before the edge entering ACK.
- REQ-043 Array contents SHALL NOT be cleared by reset.
- REQ-044 No request SHALL be accepted on the first rising edge while rst=1; acceptance SHALL resume on the first edge after deassertion.

Verification
- REQ-045 WAIT_CYCLES=2: write addr=0x10, sel=4'hF, data=0x1234_5678 at edge N -> busy_o high in cycles N+1 and N+2, ack_o high in cycle N+3 only, err_o=0.
- REQ-046 Partial write: word 0x10 holds 0x1234_5678; write sel=4'b0101, data=0xAABB_CCDD; then read 0x10 -> data_o=0x12BB_56DD.
- REQ-047 WAIT_CYCLES=0, ce held high with reads to 0x0, 0x4, 0x8 -> ack_o high three consecutive cycles, data_o updates every cycle.
- REQ-048 DEPTH_LOG2=10, BASE_ADDR=0: read addr=0x1000 -> ack_o=1, err_o=1, data_o=0; write to 0x1000 -> no word changes, including word 0.
- REQ-049 Write accepted, rst pulsed during WAIT -> all outputs 0, no ack_o; a subsequent read of that word returns the pre-write value.
- REQ-050 ce dropped to 0 one cycle after acceptance with WAIT_CYCLES=3 -> ack_o still asserted at acceptance+4 cycles.

Source files
------------

// File: rtl/data_ram_ws_if.sv
// Bus bundle for the wait-stated data RAM: request side driven by the master,
// completion/status side driven by the RAM.
interface data_ram_ws_if #(
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              ce;
    logic              we;
    logic [31:0]       addr;
    logic [NB-1:0]     sel;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              ack_o;
    logic              busy_o;
    logic              err_o;

    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o, ack_o, busy_o, err_o
    );

    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o, ack_o, busy_o, err_o
    );
endinterface

// File: rtl/data_ram_ws.sv
// Single-port byte-lane RAM with a fixed number of wait states per access.
// IDLE/ACK accept a request, WAIT counts down, ACK is the one-cycle completion.
module data_ram_ws #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    data_ram_ws_if.slave bus
);
    localparam int          NB       = DATA_W / 8;
    localparam int          LANE_LSB = $clog2(NB);
    localparam logic [32:0] SPAN     = 33'(NB) << DEPTH_LOG2;
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept;
    logic              complete;

    logic              we_q;
    logic [31:0]       addr_q;
    logic [NB-1:0]     sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // With zero wait states the access completes on its acceptance edge,
    // so the live bus inputs are used; otherwise the latched copy is.
    logic              req_we;
    logic [31:0]       req_addr;
    logic [NB-1:0]     req_sel;
    logic [DATA_W-1:0] req_wdata;
    logic [32:0]       offset;
    logic              in_range;
    logic [DEPTH_LOG2-1:0] word_idx;

    assign req_we    = (state_q == WAIT) ? we_q    : bus.we;
    assign req_addr  = (state_q == WAIT) ? addr_q  : bus.addr;
    assign req_sel   = (state_q == WAIT) ? sel_q   : bus.sel;
    assign req_wdata = (state_q == WAIT) ? wdata_q : bus.data_i;

    assign offset    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign in_range  = !offset[32] && (offset < SPAN);
    assign word_idx  = offset[LANE_LSB +: DEPTH_LOG2];

    assign complete  = (state_d == ACK) && !rst;

    always_comb begin
        // NOTE: defaults come first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, ACK: begin
                state_d = IDLE;
                if (bus.ce) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACK;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                sel_q   <= bus.sel;
                wdata_q <= bus.data_i;
            end
            err_q <= complete && !in_range;
            if (complete && !in_range)     data_q <= '0;
            else if (complete && !req_we) data_q <= mem[word_idx];
        end
    end

    // NOTE: the array is deliberately left out of reset; contents survive rst and map to plain RAM.
    always_ff @(posedge clk) begin
        if (complete && req_we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (req_sel[i]) mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    assign bus.data_o = data_q;
    assign bus.ack_o  = (state_q == ACK);
    assign bus.busy_o = (state_q == WAIT);
    assign bus.err_o  = err_q;
endmodule

// File: tb/tb_data_ram_ws.sv
// Bench for data_ram_ws: three instances (0, 2 and 3 wait states), directed
// cases plus random traffic checked against an array-based reference model.
module tb_data_ram_ws;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=2, index 2: WAIT_CYCLES=3 at 0x8000, 16 words
    logic        ce_v   [3];
    logic        we_v   [3];
    logic [31:0] addr_v [3];
    logic [3:0]  sel_v  [3];
    logic [31:0] din_v  [3];
    logic [31:0] dout_v [3];
    logic        ack_v  [3];
    logic        busy_v [3];
    logic        err_v  [3];

    data_ram_ws_if #(.DATA_W(32)) bus0 ();
    data_ram_ws_if #(.DATA_W(32)) bus1 ();
    data_ram_ws_if #(.DATA_W(32)) bus2 ();

    assign bus0.ce = ce_v[0]; assign bus0.we = we_v[0]; assign bus0.addr = addr_v[0];
    assign bus0.sel = sel_v[0]; assign bus0.data_i = din_v[0];
    assign bus1.ce = ce_v[1]; assign bus1.we = we_v[1]; assign bus1.addr = addr_v[1];
    assign bus1.sel = sel_v[1]; assign bus1.data_i = din_v[1];
    assign bus2.ce = ce_v[2]; assign bus2.we = we_v[2]; assign bus2.addr = addr_v[2];
    assign bus2.sel = sel_v[2]; assign bus2.data_i = din_v[2];

    assign dout_v[0] = bus0.data_o; assign ack_v[0] = bus0.ack_o;
    assign busy_v[0] = bus0.busy_o; assign err_v[0] = bus0.err_o;
    assign dout_v[1] = bus1.data_o; assign ack_v[1] = bus1.ack_o;
    assign busy_v[1] = bus1.busy_o; assign err_v[1] = bus1.err_o;
    assign dout_v[2] = bus2.data_o; assign ack_v[2] = bus2.ack_o;
    assign busy_v[2] = bus2.busy_o; assign err_v[2] = bus2.err_o;

    data_ram_ws #(.DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    data_ram_ws #(.DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    data_ram_ws #(.DATA_W(32), .DEPTH_LOG2(4), .WAIT_CYCLES(3), .BASE_ADDR(32'h8000))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mdl [3][1024];
    logic [31:0] exp_dout [3];

    function automatic int wc(int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic logic [31:0] base_of(int d);
        return (d == 2) ? 32'h8000 : 32'h0;
    endfunction

    function automatic logic [31:0] bytes_of(int d);
        return (d == 2) ? 32'd64 : 32'd4096;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkb(string tag, logic obs, logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(int d, logic c, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] dat);
        ce_v[d] = c; we_v[d] = w; addr_v[d] = a; sel_v[d] = s; din_v[d] = dat;
    endtask

    // One isolated access: request for one edge, then garbage on the bus while
    // the access is outstanding; checks busy/ack/err every cycle up to and after ack.
    task automatic access(int d, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] dat, string tag);
        logic oor;
        logic chk_dout;
        int   idx;
        @(negedge clk);
        drive(d, 1'b1, w, a, s, dat);
        @(posedge clk);
        oor      = (a < base_of(d)) || ((a - base_of(d)) >= bytes_of(d));
        chk_dout = !(w && oor);
        if (oor) begin
            exp_dout[d] = 32'h0;
        end else begin
            idx = int'((a - base_of(d)) >> 2);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) mdl[d][idx][8*i +: 8] = dat[8*i +: 8];
            end else begin
                exp_dout[d] = mdl[d][idx];
            end
        end
        for (int k = 1; k <= wc(d) + 1; k++) begin
            @(negedge clk);
            checkb($sformatf("%s.busy%0d", tag, k), busy_v[d], k <= wc(d));
            checkb($sformatf("%s.ack%0d", tag, k), ack_v[d], k == wc(d) + 1);
            checkb($sformatf("%s.err%0d", tag, k), err_v[d], (k == wc(d) + 1) && oor);
            if (k == wc(d) + 1 && chk_dout)
                check($sformatf("%s.dout", tag), dout_v[d], exp_dout[d]);
            if (k == 1)
                drive(d, 1'b0, 1'($urandom), $urandom, 4'($urandom), $urandom);
        end
        @(negedge clk);
        checkb($sformatf("%s.ack_end", tag), ack_v[d], 1'b0);
        checkb($sformatf("%s.err_end", tag), err_v[d], 1'b0);
    endtask

    initial begin
        logic [31:0] pre, val;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            exp_dout[d] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst.dout%0d", d), dout_v[d], 32'h0);
            checkb($sformatf("rst.ack%0d", d), ack_v[d], 1'b0);
            checkb($sformatf("rst.busy%0d", d), busy_v[d], 1'b0);
            checkb($sformatf("rst.err%0d", d), err_v[d], 1'b0);
        end
        rst = 1'b0;

        // known contents for the words the bench will read back
        for (int w = 0; w < 16; w++) access(1, 1'b1, 32'(w * 4), 4'hF, $urandom, "init1");
        for (int w = 0; w < 3; w++)  access(0, 1'b1, 32'(w * 4), 4'hF, $urandom, "init0");
        access(2, 1'b1, 32'h8000, 4'hF, $urandom, "init2");

        // basic full write with two wait states, then lane-masked update
        access(1, 1'b1, 32'h10, 4'hF, 32'h1234_5678, "w_full");
        access(1, 1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD, "w_part");
        access(1, 1'b0, 32'h10, 4'h0, 32'h0, "r_part");
        check("r_part.const", dout_v[1], 32'h12BB_56DD);
        access(1, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, "w_sel0");
        access(1, 1'b0, 32'h13, 4'h0, 32'h0, "r_sel0");
        check("r_sel0.const", dout_v[1], 32'h12BB_56DD);

        // random traffic over the first 16 words, with occasional out-of-range reads
        repeat (60) begin
            if ($urandom_range(0, 7) == 0)
                access(1, 1'b0, 32'h1000 + 32'($urandom_range(0, 32'hFFFF)), 4'($urandom), $urandom, "rnd_oor");
            else
                access(1, 1'($urandom), 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)),
                       4'($urandom), $urandom, "rnd");
        end

        // range boundary: last in-range byte, first out-of-range byte, aliasing onto word 0
        access(1, 1'b1, 32'hFFC, 4'hF, $urandom, "bnd_w");
        access(1, 1'b0, 32'hFFF, 4'h0, 32'h0, "bnd_r");
        access(1, 1'b0, 32'h1000, 4'hF, 32'h0, "oor_r");
        access(1, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, "oor_w");
        access(1, 1'b0, 32'h0, 4'hF, 32'h0, "oor_w0");
        access(1, 1'b0, 32'hFFC, 4'hF, 32'h0, "oor_wlast");

        // reset in the middle of a write; dut0 holds a write request across the reset edge
        pre = mdl[1][8];
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h20, 4'hF, ~pre);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checkb("abort.busy_pre", busy_v[1], 1'b1);
        drive(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF);
        #1 rst = 1'b1;
        #1;
        check("abort.dout", dout_v[1], 32'h0);
        checkb("abort.ack", ack_v[1], 1'b0);
        checkb("abort.busy", busy_v[1], 1'b0);
        checkb("abort.err", err_v[1], 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) exp_dout[d] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkb($sformatf("abort.noack1_%0d", k), ack_v[1], 1'b0);
            checkb($sformatf("abort.noack0_%0d", k), ack_v[0], 1'b0);
        end
        access(1, 1'b0, 32'h20, 4'hF, 32'h0, "abort.rd");
        check("abort.rd_pre", dout_v[1], pre);

        // zero wait states: write then read of the same word in back-to-back acks
        val = $urandom;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'hC, 4'hF, val);
        mdl[0][3] = val;
        @(posedge clk);
        @(negedge clk);
        checkb("b2b.ack_w", ack_v[0], 1'b1);
        drive(0, 1'b1, 1'b0, 32'hC, 4'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkb("b2b.ack_r", ack_v[0], 1'b1);
        check("b2b.dout", dout_v[0], val);
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);

        // zero wait states: three reads with ce held high, one ack per cycle
        drive(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            checkb($sformatf("stream.ack%0d", j), ack_v[0], 1'b1);
            check($sformatf("stream.dout%0d", j), dout_v[0], mdl[0][j]);
            if (j < 2) drive(0, 1'b1, 1'b0, 32'(4 * (j + 1)), 4'hF, 32'h0);
            else       drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        exp_dout[0] = mdl[0][2];
        @(negedge clk);
        checkb("stream.ack_end", ack_v[0], 1'b0);

        // three wait states, non-zero base, ce dropped after acceptance
        access(2, 1'b1, 32'h803C, 4'hF, $urandom, "ws3_lat");
        access(2, 1'b0, 32'h803F, 4'h0, 32'h0, "ws3_top");
        access(2, 1'b0, 32'h8040, 4'hF, 32'h0, "ws3_above");
        access(2, 1'b0, 32'h8000, 4'hF, 32'h0, "ws3_base");
        access(2, 1'b0, 32'h7FFF, 4'hF, 32'h0, "ws3_below");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
